// File: rtl/resetn_seq.sv
// resetn_seq: reset sequencer for the FIFO / FTDI-side logic.
// Synchronises the raw board/PLL-lock reset into clk and holds reset for a
// programmable time. It then releases N_OUT active-low reset domains one at a
// time in ascending order, starting with bit 0.
//
// Optional feature macro: RESETN_SEQ_SOFT_RST_EN
//   defined   : soft_rst_req sampled high in RUN re-runs the hold/release
//               sequence, using SOFT_HOLD as the hold length
//   undefined : soft_rst_req is ignored and no soft-reset logic is built
//
// Ports:
//   clk          in   clock
//   rstn_async   in   raw reset, asynchronous assert, active-low
//   soft_rst_req in   synchronous soft-reset request
//   rstn_out     out  [N_OUT] staged active-low resets, registered
//   ready        out  high once every rstn_out bit is released, registered
//   state        out  [2] ASSERT=0, HOLD=1, RELEASE=2, RUN=3, registered
`timescale 1ns/1ps

module resetn_seq #(
   parameter int unsigned SYNC_STAGES = 3,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_GAP   = 4,
   parameter int unsigned N_OUT       = 3,
   parameter int unsigned SOFT_HOLD   = 8
) (
   input  logic             clk,
   input  logic             rstn_async,
   input  logic             soft_rst_req,
   output logic [N_OUT-1:0] rstn_out,
   output logic             ready,
   output logic [1:0]       state
);

   localparam logic [1:0] ST_ASSERT  = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_RUN     = 2'd3;

   localparam int unsigned MAX_HS  = (HOLD_CYCLES > SOFT_HOLD) ? HOLD_CYCLES : SOFT_HOLD;
   localparam int unsigned MAX_CNT = (MAX_HS > STAGE_GAP) ? MAX_HS : STAGE_GAP;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;
   // The ASSERT->HOLD state flop acts as the final synchroniser stage.
   localparam int unsigned CHAIN   = SYNC_STAGES - 1;

   logic [CHAIN-1:0] sync_q;
   logic             sync_out;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [1:0]       state_d;
   logic [N_OUT-1:0] rstn_d;
   logic [N_OUT-1:0] next_mask;
   logic             ready_d;

   // Reset synchroniser: async clear, shifts in ones.
   always_ff @(posedge clk or negedge rstn_async) begin
      if (!rstn_async) sync_q <= '0;
      else             sync_q <= CHAIN'({sync_q, 1'b1});
   end

   assign sync_out = sync_q[CHAIN-1];

   // Next release pattern: one more bit released above those already high.
   assign next_mask = N_OUT'({rstn_out, 1'b1});

`ifndef RESETN_SEQ_SOFT_RST_EN
   logic unused_soft;
   assign unused_soft = soft_rst_req;
`endif

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rstn_async) begin
      if (!rstn_async) begin
         state    <= ST_ASSERT;
         cnt_q    <= '0;
         rstn_out <= '0;
         ready    <= 1'b0;
      end else begin
         state    <= state_d;
         cnt_q    <= cnt_d;
         rstn_out <= rstn_d;
         ready    <= ready_d;
      end
   end

   // Next-state logic. The counter only decrements when nonzero, so it never wraps.
   always_comb begin
      state_d = state;
      cnt_d   = cnt_q;
      rstn_d  = rstn_out;
      ready_d = ready;
      case (state)
         ST_ASSERT: begin
            rstn_d  = '0;
            ready_d = 1'b0;
            if (sync_out) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end
         end
         ST_HOLD, ST_RELEASE: begin
            if (cnt_q == '0) begin
               rstn_d = next_mask;
               if (next_mask[N_OUT-1]) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_RELEASE;
                  cnt_d   = CNT_W'(STAGE_GAP - 1);
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RUN: begin
`ifdef RESETN_SEQ_SOFT_RST_EN
            if (soft_rst_req) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(SOFT_HOLD - 1);
               rstn_d  = '0;
               ready_d = 1'b0;
            end
`endif
         end
         default: begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            rstn_d  = '0;
            ready_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_resetn_seq.sv
// tb_resetn_seq: directed, table-driven bench for resetn_seq.
// Covers the default instance and a minimal instance (N_OUT=1, HOLD_CYCLES=1,
// STAGE_GAP=1, SYNC_STAGES=2) that shares the same clock and reset.
`timescale 1ns/1ps

module tb_resetn_seq;

   typedef struct {
      int         e;
      logic [2:0] rstn;
      logic       rdy;
      logic [1:0] st;
   } vec_t;

   localparam int NV = 10;
   localparam int NS = 7;

   logic       clk = 1'b0;
   logic       rstn_async = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic [2:0] rstn_out;
   logic       ready;
   logic [1:0] state;
   logic [0:0] small_rstn;
   logic       small_ready;
   logic [1:0] small_state;

   int checks = 0;
   int errors = 0;

   vec_t pon[NV];
   vec_t soft_tbl[NS];

   always #5 clk = ~clk;

   resetn_seq dut (
      .clk          (clk),
      .rstn_async   (rstn_async),
      .soft_rst_req (soft_rst_req),
      .rstn_out     (rstn_out),
      .ready        (ready),
      .state        (state)
   );

   resetn_seq #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (1),
      .STAGE_GAP   (1),
      .N_OUT       (1),
      .SOFT_HOLD   (8)
   ) dut_small (
      .clk          (clk),
      .rstn_async   (rstn_async),
      .soft_rst_req (soft_rst_req),
      .rstn_out     (small_rstn),
      .ready        (small_ready),
      .state        (small_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] r, input logic rd, input logic [1:0] s);
      check({name, ".rstn_out"}, 32'(rstn_out), 32'(r));
      check({name, ".ready"},    32'(ready),    32'(rd));
      check({name, ".state"},    32'(state),    32'(s));
   endtask

   // Edges are counted from the next posedge (E0); samples are taken 1ns after each edge.
   task automatic run_table(input string name, input int soft_lo, input int soft_hi, input int last);
      int idx = 0;
      for (int e = 0; e <= last; e++) begin
         soft_rst_req = (e >= soft_lo && e <= soft_hi);
         @(posedge clk);
         #1;
         if (idx < NV && pon[idx].e == e) begin
            check_all($sformatf("%s.E%0d", name, e), pon[idx].rstn, pon[idx].rdy, pon[idx].st);
            idx++;
         end
         if (e == 1) begin
            check($sformatf("%s.small.E1.state", name), 32'(small_state), 32'd1);
            check($sformatf("%s.small.E1.rstn", name),  32'(small_rstn),  32'd0);
            check($sformatf("%s.small.E1.ready", name), 32'(small_ready), 32'd0);
         end
         if (e == 2) begin
            check($sformatf("%s.small.E2.state", name), 32'(small_state), 32'd3);
            check($sformatf("%s.small.E2.rstn", name),  32'(small_rstn),  32'd1);
            check($sformatf("%s.small.E2.ready", name), 32'(small_ready), 32'd1);
         end
      end
      soft_rst_req = 1'b0;
   endtask

   initial begin
      pon[0] = '{0,  3'b000, 1'b0, 2'd0};
      pon[1] = '{1,  3'b000, 1'b0, 2'd0};
      pon[2] = '{2,  3'b000, 1'b0, 2'd1};
      pon[3] = '{17, 3'b000, 1'b0, 2'd1};
      pon[4] = '{18, 3'b001, 1'b0, 2'd2};
      pon[5] = '{21, 3'b001, 1'b0, 2'd2};
      pon[6] = '{22, 3'b011, 1'b0, 2'd2};
      pon[7] = '{25, 3'b011, 1'b0, 2'd2};
      pon[8] = '{26, 3'b111, 1'b1, 2'd3};
      pon[9] = '{30, 3'b111, 1'b1, 2'd3};
`ifdef RESETN_SEQ_SOFT_RST_EN
      soft_tbl[0] = '{0,  3'b000, 1'b0, 2'd1};
      soft_tbl[1] = '{7,  3'b000, 1'b0, 2'd1};
      soft_tbl[2] = '{8,  3'b001, 1'b0, 2'd2};
      soft_tbl[3] = '{11, 3'b001, 1'b0, 2'd2};
      soft_tbl[4] = '{12, 3'b011, 1'b0, 2'd2};
      soft_tbl[5] = '{15, 3'b011, 1'b0, 2'd2};
      soft_tbl[6] = '{16, 3'b111, 1'b1, 2'd3};
`else
      soft_tbl[0] = '{0,  3'b111, 1'b1, 2'd3};
      soft_tbl[1] = '{7,  3'b111, 1'b1, 2'd3};
      soft_tbl[2] = '{8,  3'b111, 1'b1, 2'd3};
      soft_tbl[3] = '{11, 3'b111, 1'b1, 2'd3};
      soft_tbl[4] = '{12, 3'b111, 1'b1, 2'd3};
      soft_tbl[5] = '{15, 3'b111, 1'b1, 2'd3};
      soft_tbl[6] = '{16, 3'b111, 1'b1, 2'd3};
`endif

      // Power-on: reset low for 5 cycles.
      repeat (5) @(posedge clk);
      #1;
      check_all("reset", 3'b000, 1'b0, 2'd0);
      check("reset.small.rstn", 32'(small_rstn), 32'd0);
      @(negedge clk);
      rstn_async = 1'b1;
      run_table("pon", -1, -1, 30);

      // Soft request held through HOLD and dropped before RUN changes nothing.
      @(negedge clk);
      rstn_async = 1'b0;
      repeat (2) @(negedge clk);
      rstn_async = 1'b1;
      run_table("soft_in_hold", 3, 10, 30);

      // Abort during RELEASE: clear is immediate, without a clock edge.
      @(negedge clk);
      rstn_async = 1'b0;
      repeat (2) @(negedge clk);
      rstn_async = 1'b1;
      run_table("pre_abort", -1, -1, 23);
      #2;
      rstn_async = 1'b0;
      #1;
      check_all("abort", 3'b000, 1'b0, 2'd0);
      check("abort.small.ready", 32'(small_ready), 32'd0);
      repeat (2) @(negedge clk);
      rstn_async = 1'b1;
      run_table("post_abort", -1, -1, 30);

      // Short glitch mid-RUN (3ns of a 10ns period) still clears everything.
      @(posedge clk);
      #2;
      rstn_async = 1'b0;
      #1;
      check_all("glitch", 3'b000, 1'b0, 2'd0);
      #2;
      rstn_async = 1'b1;
      run_table("post_glitch", -1, -1, 30);

      // Single-cycle soft request sampled in RUN at edge S.
      soft_rst_req = 1'b1;
      begin
         int idx = 0;
         for (int j = 0; j <= 17; j++) begin
            @(posedge clk);
            #1;
            soft_rst_req = 1'b0;
            if (idx < NS && soft_tbl[idx].e == j) begin
               check_all($sformatf("soft.S+%0d", j), soft_tbl[idx].rstn, soft_tbl[idx].rdy, soft_tbl[idx].st);
               idx++;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
